// File: rtl/multi_alarm_clock.sv
`default_nettype none
// ============================================================================
// Module   : multi_alarm_clock
// Purpose  : 24h BCD time-of-day clock with N alarm slots, per-slot enables,
//            snooze and ring auto-timeout. The 1 Hz rate is a clock-enable
//            (sec_tick) derived from a clk divider.
// Revision : 1.0 - initial release
// ============================================================================
module multi_alarm_clock #(
  parameter int CLK_PER_SEC  = 10,
  parameter int N_ALARMS     = 4,
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60,
  parameter int AW           = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          H_in1,
  input  logic [3:0]          H_in0,
  input  logic [3:0]          M_in1,
  input  logic [3:0]          M_in0,
  input  logic                LD_time,
  input  logic                LD_alarm,
  input  logic [AW-1:0]       alarm_sel,
  input  logic [N_ALARMS-1:0] AL_EN,
  input  logic                STOP_al,
  input  logic                SNOOZE,
  output logic                Alarm,
  output logic [AW-1:0]       alarm_id,
  output logic                snoozed,
  output logic                sec_tick,
  output logic [1:0]          H_out1,
  output logic [3:0]          H_out0,
  output logic [3:0]          M_out1,
  output logic [3:0]          M_out0,
  output logic [3:0]          S_out1,
  output logic [3:0]          S_out0
);

  localparam int DW = $clog2(CLK_PER_SEC);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2
  } state_t;

  // Time-keeping state
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    h1_q, h1_d;
  logic [3:0]    h0_q, h0_d, m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
  logic          upd_q, upd_d;   // time changed on the previous edge
  logic [N_ALARMS-1:0][13:0] slot_q, slot_d;

  // Alarm FSM state
  state_t        state_q, state_d;
  logic [AW-1:0] alarm_id_q, alarm_id_d;
  logic [7:0]    ring_cnt_q, ring_cnt_d;
  logic [4:0]    tgt_h_q, tgt_h_d;
  logic [5:0]    tgt_m_q, tgt_m_d;

  // Combinational helpers
  logic          in_ok;
  logic          at_zero_sec;
  logic          match;
  logic [AW-1:0] match_id;
  logic [4:0]    cur_h_bin, snz_h;
  logic [5:0]    cur_m_bin, snz_m;
  logic [6:0]    m_sum;
  logic          snooze_hit;

  assign sec_tick    = (div_q == DW'(CLK_PER_SEC - 1));
  assign at_zero_sec = (s1_q == 4'd0) && (s0_q == 4'd0);
  assign in_ok = (H_in0 <= 4'd9) && (M_in1 <= 4'd5) && (M_in0 <= 4'd9) &&
                 ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
  assign cur_h_bin = 5'(h1_q) * 5'd10 + 5'(h0_q);
  assign cur_m_bin = 6'(m1_q) * 6'd10 + 6'(m0_q);
  assign snooze_hit = upd_q && at_zero_sec &&
                      (cur_h_bin == tgt_h_q) && (cur_m_bin == tgt_m_q);

  // Divider, BCD time ripple, time load and alarm-slot load
  always_comb begin
    div_d  = div_q;
    h1_d   = h1_q;
    h0_d   = h0_q;
    m1_d   = m1_q;
    m0_d   = m0_q;
    s1_d   = s1_q;
    s0_d   = s0_q;
    upd_d  = 1'b0;
    slot_d = slot_q;
    if (LD_time && in_ok) begin
      h1_d  = H_in1;
      h0_d  = H_in0;
      m1_d  = M_in1;
      m0_d  = M_in0;
      s1_d  = 4'd0;
      s0_d  = 4'd0;
      div_d = '0;
      upd_d = 1'b1;
    end else begin
      div_d = sec_tick ? '0 : div_q + DW'(1);
      if (sec_tick) begin
        upd_d = 1'b1;
        if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
        else begin
          s0_d = 4'd0;
          if (s1_q != 4'd5) s1_d = s1_q + 4'd1;
          else begin
            s1_d = 4'd0;
            if (m0_q != 4'd9) m0_d = m0_q + 4'd1;
            else begin
              m0_d = 4'd0;
              if (m1_q != 4'd5) m1_d = m1_q + 4'd1;
              else begin
                m1_d = 4'd0;
                if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                  h1_d = 2'd0;
                  h0_d = 4'd0;
                end else if (h0_q == 4'd9) begin
                  h0_d = 4'd0;
                  h1_d = h1_q + 2'd1;
                end else begin
                  h0_d = h0_q + 4'd1;
                end
              end
            end
          end
        end
      end
    end
    if (LD_alarm && in_ok && (32'(alarm_sel) < N_ALARMS))
      slot_d[alarm_sel] = {H_in1, H_in0, M_in1, M_in0};
  end

  // Lowest enabled slot equal to a freshly reached hh:mm:00
  always_comb begin
    match    = 1'b0;
    match_id = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (AL_EN[i] && (slot_q[i] == {h1_q, h0_q, m1_q, m0_q})) begin
        match    = upd_q && at_zero_sec;
        match_id = AW'(i);
      end
    end
  end

  // Snooze target: current hh:mm plus SNOOZE_MIN, wrapping at 24h
  always_comb begin
    m_sum = 7'(cur_m_bin) + 7'(SNOOZE_MIN);
    snz_h = cur_h_bin;
    snz_m = 6'(m_sum);
    if (m_sum >= 7'd60) begin
      snz_m = 6'(m_sum - 7'd60);
      snz_h = (cur_h_bin == 5'd23) ? 5'd0 : cur_h_bin + 5'd1;
    end
  end

  // Alarm FSM next-state: STOP beats SNOOZE, which beats timeout
  always_comb begin
    state_d    = state_q;
    alarm_id_d = alarm_id_q;
    ring_cnt_d = ring_cnt_q;
    tgt_h_d    = tgt_h_q;
    tgt_m_d    = tgt_m_q;
    case (state_q)
      ST_IDLE: begin
        if (match) begin
          state_d    = ST_RINGING;
          alarm_id_d = match_id;
          ring_cnt_d = 8'd0;
        end
      end
      ST_RINGING: begin
        if (STOP_al) begin
          state_d = ST_IDLE;
        end else if (SNOOZE) begin
          state_d = ST_SNOOZED;
          tgt_h_d = snz_h;
          tgt_m_d = snz_m;
        end else if (sec_tick) begin
          if (ring_cnt_q == 8'(RING_TIMEOUT - 1)) state_d = ST_IDLE;
          else ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      ST_SNOOZED: begin
        if (STOP_al || !AL_EN[alarm_id_q]) begin
          state_d = ST_IDLE;
        end else if (snooze_hit) begin
          state_d    = ST_RINGING;
          ring_cnt_d = 8'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      h1_q       <= 2'd0;
      h0_q       <= 4'd0;
      m1_q       <= 4'd0;
      m0_q       <= 4'd0;
      s1_q       <= 4'd0;
      s0_q       <= 4'd0;
      upd_q      <= 1'b0;
      slot_q     <= '0;
      state_q    <= ST_IDLE;
      alarm_id_q <= '0;
      ring_cnt_q <= 8'd0;
      tgt_h_q    <= 5'd0;
      tgt_m_q    <= 6'd0;
    end else begin
      div_q      <= div_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      s1_q       <= s1_d;
      s0_q       <= s0_d;
      upd_q      <= upd_d;
      slot_q     <= slot_d;
      state_q    <= state_d;
      alarm_id_q <= alarm_id_d;
      ring_cnt_q <= ring_cnt_d;
      tgt_h_q    <= tgt_h_d;
      tgt_m_q    <= tgt_m_d;
    end
  end

  assign Alarm    = (state_q == ST_RINGING);
  assign snoozed  = (state_q == ST_SNOOZED);
  assign alarm_id = alarm_id_q;
  assign H_out1   = h1_q;
  assign H_out0   = h0_q;
  assign M_out1   = m1_q;
  assign M_out0   = m0_q;
  assign S_out1   = s1_q;
  assign S_out0   = s0_q;

endmodule
`default_nettype wire
